// File: rtl/sgdmac_write_engine.sv
// SGDMAC write-side mover: drains the read-data FIFO into AXI INCR write bursts
// of up to MAX_BURST beats that never straddle a 4 KB page.
`timescale 1ns/1ps
module sgdmac_write_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // command from descriptor engine
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [15:0]           cmd_len_i,
  output logic                  done_o,
  output logic                  err_o,
  // read-data FIFO head
  input  logic                  fifo_empty_i,
  output logic                  fifo_rden_o,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  // AXI write address
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic [3:0]            awlen_o,
  output logic [2:0]            awsize_o,
  output logic [1:0]            awburst_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  // AXI write data
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [3:0]            wstrb_o,
  output logic                  wlast_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  // AXI write response
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o
);

  localparam int         REM_W  = 14;
  localparam int         BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [REM_W-1:0]      rem_q;
  logic [BEAT_W-1:0]     beats_q;
  logic [BEAT_W-1:0]     cnt_q;
  logic [3:0]            awlen_q;
  logic                  cmd_ready_q;
  logic                  awvalid_q;
  logic                  wlast_q;
  logic                  bready_q;
  logic                  done_q;
  logic                  err_q;

  logic [ADDR_WIDTH-1:0] cmd_addr_al;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [REM_W-1:0]      cmd_words;
  logic [REM_W-1:0]      rem_d;
  logic [BEAT_W-1:0]     cmd_beats;
  logic [BEAT_W-1:0]     next_beats;
  logic                  aw_fire;
  logic                  w_fire;
  logic                  b_fire;
  logic                  unused_bits;

  // Beats for the next burst: limited by words left, MAX_BURST and the words
  // remaining before the next 4 KB page (only addr[11:2] matters for that).
  function automatic logic [BEAT_W-1:0] burst_beats(input logic [9:0]       word_off,
                                                    input logic [REM_W-1:0] rem);
    logic [REM_W-1:0] n;
    logic [REM_W-1:0] to_bound;
    to_bound = REM_W'(11'd1024 - {1'b0, word_off});
    n = rem;
    if (n > REM_W'(MAX_BURST)) n = REM_W'(MAX_BURST);
    if (to_bound < n) n = to_bound;
    return BEAT_W'(n);
  endfunction

  assign cmd_addr_al = {cmd_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign cmd_words   = cmd_len_i[15:2];
  assign addr_d      = addr_q + ADDR_WIDTH'({beats_q, 2'b00});
  assign rem_d       = rem_q - REM_W'(beats_q);
  assign cmd_beats   = burst_beats(cmd_addr_i[11:2], cmd_words);
  assign next_beats  = burst_beats(addr_d[11:2], rem_d);
  assign unused_bits = ^{cmd_addr_i[1:0], cmd_len_i[1:0]};

  // W path is combinational from the FIFO flag so a pop never happens while empty.
  assign wvalid_o    = (state_q == ST_W) && !fifo_empty_i;
  assign w_fire      = wvalid_o && wready_i;
  assign fifo_rden_o = w_fire;
  assign wdata_o     = fifo_rdata_i;
  assign aw_fire     = awvalid_q && awready_i;
  assign b_fire      = bready_q && bvalid_i;

  assign cmd_ready_o = cmd_ready_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign awaddr_o    = awaddr_q;
  assign awlen_o     = awlen_q;
  assign awsize_o    = AXSIZE;
  assign awburst_o   = 2'b01;
  assign awvalid_o   = awvalid_q;
  assign wstrb_o     = 4'hF;
  assign wlast_o     = wlast_q;
  assign bready_o    = bready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      awaddr_q    <= '0;
      rem_q       <= '0;
      beats_q     <= '0;
      cnt_q       <= '0;
      awlen_q     <= '0;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            err_q <= 1'b0;
            // A zero-word command completes without touching the bus.
            if (cmd_words == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q      <= cmd_addr_al;
              rem_q       <= cmd_words;
              beats_q     <= cmd_beats;
              cnt_q       <= cmd_beats;
              awaddr_q    <= cmd_addr_al;
              awlen_q     <= 4'(cmd_beats - 1'b1);
              awvalid_q   <= 1'b1;
              cmd_ready_q <= 1'b0;
              state_q     <= ST_AW;
            end
          end
        end
        ST_AW: begin
          if (aw_fire) begin
            awvalid_q <= 1'b0;
            wlast_q   <= (cnt_q == BEAT_W'(1));
            state_q   <= ST_W;
          end
        end
        ST_W: begin
          if (w_fire) begin
            cnt_q   <= cnt_q - 1'b1;
            wlast_q <= (cnt_q == BEAT_W'(2));
            if (wlast_q) begin
              bready_q <= 1'b1;
              state_q  <= ST_B;
            end
          end
        end
        ST_B: begin
          if (b_fire) begin
            if (bresp_i != 2'b00) err_q <= 1'b1;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            bready_q <= 1'b0;
            if (rem_d == '0) begin
              cmd_ready_q <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              beats_q   <= next_beats;
              cnt_q     <= next_beats;
              awaddr_q  <= addr_d;
              awlen_q   <= 4'(next_beats - 1'b1);
              awvalid_q <= 1'b1;
              state_q   <= ST_AW;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
